// File: rtl/load_responder.sv
// Memory-side load responder: request FIFO feeding a fixed-latency read of a small backing store.
// Optional LOAD_RESP_STATS_EN adds a saturating resp_count output.
module load_responder #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ld_req,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  data_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
`ifdef LOAD_RESP_STATS_EN
   output logic [7:0]            resp_count,
`endif
   output logic                  overflow
);

   localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
   localparam int IDX_W     = $clog2(FIFO_DEPTH);
   localparam int PTR_W     = IDX_W + 1;
   localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    dv_q, dv_d;
   logic                    ovf_q, ovf_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   fifo_d [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_q  [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d  [MEM_DEPTH];

   logic fifo_empty, fifo_full, pop, push;

   // A full FIFO still accepts a request when the FSM pops in the same cycle.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
      pop        = (state_q == S_IDLE) && !fifo_empty;
      push       = ld_req && (!fifo_full || pop);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fifo_d   = fifo_q;
      ovf_d    = ovf_q | (ld_req & ~push);
      if (push) begin
         fifo_d[wr_ptr_q[IDX_W-1:0]] = addr;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // Store reads use mem_q, so a same-edge write is seen only by later loads.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_addr_d = lat_addr_q;
      data_d     = data_q;
      dv_d       = dv_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               lat_addr_d = fifo_q[rd_ptr_q[IDX_W-1:0]];
               cnt_d      = CNT_W'(LATENCY - 1);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               data_d  = mem_q[lat_addr_q];
               dv_d    = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            dv_d    = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            dv_d    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lat_addr_q <= '0;
         data_q     <= '0;
         dv_q       <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         for (int i = 0; i < MEM_DEPTH; i++)  mem_q[i]  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_addr_q <= lat_addr_d;
         data_q     <= data_d;
         dv_q       <= dv_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_q     <= fifo_d;
         mem_q      <= mem_d;
      end
   end

`ifdef LOAD_RESP_STATS_EN
   logic [7:0] resp_cnt_q, resp_cnt_d;

   always_comb begin
      resp_cnt_d = resp_cnt_q;
      if (state_q == S_WAIT && cnt_q == '0 && resp_cnt_q != 8'hFF) begin
         resp_cnt_d = resp_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) resp_cnt_q <= '0;
      else          resp_cnt_q <= resp_cnt_d;
   end

   assign resp_count = resp_cnt_q;
`endif

   assign data       = data_q;
   assign data_valid = dv_q;
   assign overflow   = ovf_q;
   assign busy       = !fifo_empty || (state_q != S_IDLE);

endmodule
